key_conditioner: RTL

- Front-end for the clock/alarm/stopwatch controller. Conditions the raw panel buttons (Pulse, QD, CLR) before they drive position-select, digit-increment and clear logic.
- Per key: 2-FF synchronizer, polarity normalisation, debounce, single-cycle press/release pulses, long-press detection and auto-repeat for fast digit setting.
- Runs entirely on the 1 kHz system clock, so one clock cycle = 1 ms.

---
 rtl/key_pkg.sv | 31 +++
 rtl/key_fsm.sv | 139 +++++++++++++
 rtl/key_conditioner.sv | 52 +++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the panel key conditioner.
// Holds the per-key state encoding, the counter-width helper functions and
// the default timing constants (one clock cycle = 1 ms on the 1 kHz clock).
package key_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } key_state_t;

    localparam int DEF_NUM_KEYS        = 3;
    localparam int DEF_DEBOUNCE_MS     = 20;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_RATE_MS  = 200;

    // Ceiling log2 with a floor of 1 so every counter has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_fsm.sv
// One conditioned key: polarity normalisation, 2-FF synchronizer, debounce,
// press/release pulses, long-press flag and optional auto-repeat.
// Ports:
//   clk_1khz    - 1 kHz system clock
//   switch_clr  - asynchronous active-low reset
//   key_raw     - unsynchronised button level
//   key_level   - debounced level, 1 = pressed
//   key_press   - one-cycle pulse on accepted press
//   key_release - one-cycle pulse on accepted release
//   key_long    - high from hold threshold until accepted release
//   key_repeat  - one-cycle auto-repeat pulses
module key_fsm
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic clk_1khz,
    input  logic switch_clr,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CNT_W  = clog2(DEBOUNCE_MS);
    localparam int HOLD_W = clog2(max2(REPEAT_DELAY_MS, REPEAT_RATE_MS));

    localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_MS - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_MS - 1);

    key_state_t        state;
    logic [1:0]        sync_q;
    logic              sync;
    logic              norm;
    logic              ret_repeat;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;

    // Polarity is fixed before synchronizing so the reset value 0 is always
    // the released level regardless of the key's electrical polarity.
    assign norm = key_raw ^ ACTIVE_LOW;
    assign sync = sync_q[1];

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            sync_q      <= 2'b00;
            state       <= IDLE;
            ret_repeat  <= 1'b0;
            cnt         <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], norm};
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    // A release always wins over the threshold; the hold count
                    // still ticks on the leaving cycle unless already at the
                    // threshold, so a short dropout delays key_long by exactly
                    // the dropout length.
                    if (!sync) begin
                        state      <= RELEASE_DB;
                        cnt        <= '0;
                        ret_repeat <= 1'b0;
                        if (hold_cnt != DELAY_LAST) hold_cnt <= hold_cnt + 1'b1;
                    end else if (hold_cnt == DELAY_LAST) begin
                        key_long <= 1'b1;
                        if (REPEAT_EN) begin
                            key_repeat <= 1'b1;
                            state      <= REPEAT;
                            hold_cnt   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!sync) begin
                        state      <= RELEASE_DB;
                        cnt        <= '0;
                        ret_repeat <= 1'b1;
                        if (hold_cnt != RATE_LAST) hold_cnt <= hold_cnt + 1'b1;
                    end else if (hold_cnt == RATE_LAST) begin
                        key_repeat <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE_DB: begin
                    // hold_cnt is frozen here; a bounce back resumes where it left off.
                    if (sync) begin
                        state <= ret_repeat ? REPEAT : HELD;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        key_long    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Panel key front-end for the clock/alarm/stopwatch controller.
// Instantiates one independent key_fsm per button with its own polarity
// and auto-repeat enable.
// Ports:
//   clk_1khz    - 1 kHz system clock
//   switch_clr  - asynchronous active-low reset
//   key_raw     - unsynchronised button levels
//   key_level   - debounced levels, 1 = pressed
//   key_press   - one-cycle pulses on accepted press
//   key_release - one-cycle pulses on accepted release
//   key_long    - long-press flags
//   key_repeat  - one-cycle auto-repeat pulses
module key_conditioner
    import key_pkg::*;
#(
    parameter int                  NUM_KEYS        = DEF_NUM_KEYS,
    parameter logic [NUM_KEYS-1:0] ACTIVE_LOW_MASK = 3'b100,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 3'b010,
    parameter int                  DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int                  REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int                  REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic                clk_1khz,
    input  logic                switch_clr,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_fsm #(
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_key (
            .clk_1khz    (clk_1khz),
            .switch_clr  (switch_clr),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule
